// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Iterative RV32M multiply/divide sequencer (shift-add / restoring)
// Revision : 1.0
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   c_cnt_last = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_all_ones = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_func3;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [XLEN-1:0] r_acc_hi;   // product high half / partial remainder
    logic [XLEN-1:0] r_acc_lo;   // product low half (multiplier) / quotient (dividend)
    logic [XLEN-1:0] r_opnd;     // multiplicand / divisor magnitude
    logic [XLEN-1:0] r_result;

    // ---------------------------------------------------------------- capture
    logic            w_idle;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_result;

    assign w_idle = (r_state == S_IDLE);

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
    assign w_sign_a = op_a[XLEN-1] & ((func3 == 3'b001) | (func3 == 3'b010) |
                                      (func3 == 3'b100) | (func3 == 3'b110));
    assign w_sign_b = op_b[XLEN-1] & ((func3 == 3'b001) | (func3 == 3'b100) |
                                      (func3 == 3'b110));
    assign w_mag_a  = w_sign_a ? -op_a : op_a;
    assign w_mag_b  = w_sign_b ? -op_b : op_b;

    assign w_div0    = (op_b == '0);
    assign w_ovf     = ~func3[0] & (op_a == c_int_min) & (op_b == c_all_ones);
    assign w_special = func3[2] & (w_div0 | w_ovf);

    always_comb begin
        w_special_result = '0;
        if (w_div0)
            w_special_result = func3[1] ? op_a : c_all_ones;
        else
            w_special_result = func3[1] ? '0 : op_a;
    end

    // ----------------------------------------------------------- iteration step
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ok;

    assign w_mul_sum   = {1'b0, r_acc_hi} + ({1'b0, r_opnd} & {(XLEN+1){r_acc_lo[0]}});
    assign w_div_shift = {r_acc_hi, r_acc_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ok    = ~w_div_diff[XLEN];

    // ------------------------------------------------------------ sign fix-up
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_sign_a ? -r_acc_hi : r_acc_hi;

    always_comb begin
        w_fix_result = '0;
        if (r_func3[2])
            w_fix_result = r_func3[1] ? w_rem_fix : w_quo_fix;
        else if (r_func3[1:0] == 2'b00)
            w_fix_result = w_prod_fix[XLEN-1:0];
        else
            w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
    end

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_next = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == c_cnt_last)
                    w_state_next = S_FIX;
            end
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (kill)
            w_state_next = S_IDLE;
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_func3  <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else if (!kill) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_func3  <= func3;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_cnt    <= '0;
                        r_acc_hi <= '0;
                        r_acc_lo <= func3[2] ? w_mag_a : w_mag_b;
                        r_opnd   <= func3[2] ? w_mag_b : w_mag_a;
                        if (w_special)
                            r_result <= w_special_result;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_func3[2]) begin
                        r_acc_hi <= w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
                        r_acc_lo <= {r_acc_lo[XLEN-2:0], w_div_ok};
                    end else begin
                        r_acc_hi <= w_mul_sum[XLEN:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == S_CALC) | (r_state == S_FIX);
    assign stall  = (start & w_idle) | busy;
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Directed vector bench for muldiv_seq
// Revision : 1.0
// ============================================================================
module tb_muldiv_seq;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            kill;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    int n_vec;
    int n_err;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .kill   (kill),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        bit stall_ok;
        @(negedge clk);
        func3 = f3; op_a = a; op_b = b; start = 1'b1;
        #1 check($sformatf("v%0d stall@accept", idx), 32'(stall), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        stall_ok = 1'b1;
        while (!done && cyc < 60) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        check($sformatf("v%0d stall while busy", idx), 32'(stall_ok), 32'd1);
        check($sformatf("v%0d done cycle", idx), 32'(cyc), 32'(lat));
        check($sformatf("v%0d done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d result", idx), result, exp);
        check($sformatf("v%0d stall@done", idx), 32'(stall), 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d done pulse width", idx), 32'(done), 32'd0);
        check($sformatf("v%0d result hold", idx), result, exp);
    endtask

    task automatic expect_no_done(input string name, input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{3'b000, 32'd7,          32'd6,          32'd42,         34};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,          32'd14,         34};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,          32'd2,          34};
        vecs[8]  = '{3'b100, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[9]  = '{3'b110, 32'h0000_1234,  32'd0,          32'h0000_1234,  1};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[12] = '{3'b101, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[13] = '{3'b111, 32'h0000_1234,  32'd0,          32'h0000_1234,  1};
        vecs[14] = '{3'b000, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  34};
        vecs[15] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        vecs[16] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
        vecs[17] = '{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};

        rst = 1'b1; start = 1'b0; kill = 1'b0; func3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   32'(busy),  32'd0);
        check("reset stall",  32'(stall), 32'd0);
        check("reset done",   32'(done),  32'd0);
        check("reset result", result,     32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++)
            run_op(i, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // kill at cycle 10 of a DIV
        @(negedge clk);
        func3 = 3'b100; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 10; cyc++) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        n_vec++;
        check("kill busy@11", 32'(busy), 32'd0);
        check("kill done@11", 32'(done), 32'd0);
        expect_no_done("kill no done", 40);

        // start coincident with kill is dropped
        @(negedge clk);
        func3 = 3'b000; op_a = 32'd3; op_b = 32'd3; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        n_vec++;
        check("start+kill busy", 32'(busy), 32'd0);
        expect_no_done("start+kill no done", 40);

        // second start at cycle 5 of a MUL, and a start during DONE, are both ignored
        @(negedge clk);
        func3 = 3'b000; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            if (cyc == 5) begin
                start = 1'b1; func3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        check("restart done cycle", 32'(cyc), 32'd34);
        check("restart result", result, 32'd15);
        start = 1'b1; func3 = 3'b000; op_a = 32'd2; op_b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check("start in DONE busy", 32'(busy), 32'd0);
        check("start in DONE done", 32'(done), 32'd0);
        expect_no_done("restart single done", 40);
        check("restart result held", result, 32'd15);

        // rst at cycle 20 of a MUL
        @(negedge clk);
        func3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 20; cyc++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        check("rst busy",   32'(busy),  32'd0);
        check("rst stall",  32'(stall), 32'd0);
        check("rst done",   32'(done),  32'd0);
        check("rst result", result,     32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_no_done("rst no done", 40);

        run_op(99, 3'b011, 32'd1000, 32'd1000, 32'd0, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions, next to the single-cycle ALU in the execute stage. When the decoder flags an M-extension op (opcode OP, func7 = 0000001), execute hands the operands and func3 to this block. The block holds the pipeline stall and runs a shift-add multiply or a restoring divide, one bit per cycle. It then returns a sign-corrected XLEN-bit result with a one-cycle done pulse.

## Interface
- XLEN, 32: operand/result width; counter width is clog2(XLEN)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- func3  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  XLEN  rs1 value; sampled with start
- op_b  in  XLEN  rs2 value; sampled with start
- kill  in  1  pipeline flush; aborts any operation in progress
- busy  out  1  high in CALC and FIX
- stall  out  1  = (start & IDLE) | busy; freezes the upstream pipeline
- done  out  1  one-cycle pulse in DONE
- result  out  XLEN  valid only while done = 1; holds last value otherwise

## Operation
- States and transitions:
  - IDLE: start=1 and special case → DONE; start=1 otherwise → CALC; else stay.
  - CALC: runs XLEN cycles; leaves when cnt = XLEN-1 → FIX.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- Operand capture on accept:
  - Latch func3.
  - sign_a = op_a[XLEN-1] for MULH, MULHSU, DIV, REM; else 0.
  - sign_b = op_b[XLEN-1] for MULH, DIV, REM; else 0. MUL uses unsigned magnitudes (low word is sign-independent).
  - Store magnitudes |op_a| and |op_b| according to sign_a / sign_b.
  - cnt = 0.
- Multiply (func3[2]=0):
  - 2·XLEN product register; each CALC cycle adds the multiplicand if the current multiplier LSB is 1, then shifts right 1.
  - FIX: negate the 2·XLEN product (two's complement) if sign_a ^ sign_b.
  - Result: MUL takes the low XLEN bits; MULH, MULHSU and MULHU take the high XLEN bits.
- Divide (func3[2]=1):
  - Restoring: each cycle shifts {rem, quo} left 1 and trial-subtracts the divisor from rem using an XLEN+1-bit subtract.
  - If non-negative: keep the difference and set the quotient LSB to 1; else restore.
  - FIX: negate the quotient if sign_a ^ sign_b; negate the remainder if sign_a.
  - Result: DIV/DIVU take the quotient; REM/REMU take the remainder.
- Special cases, detected in IDLE, bypass CALC/FIX; result is loaded directly and done comes in DONE:
  - Divide by zero (op_b = 0): DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (DIV/REM, op_a = 1<<(XLEN-1), op_b = all ones): DIV → op_a; REM → 0.
  - Multiply has no special cases.
- kill (has priority over everything except rst):
  - Forces the state to IDLE next cycle.
  - done is not asserted for the aborted op.
  - start in the same cycle as kill is ignored.
- start while not IDLE is ignored; there is no queueing.
- Reset values: state IDLE, cnt 0, busy 0, stall 0, done 0, result 0; all internal registers 0.

## Timing
- Start accepted at edge E0 (cycle 0):
  - Normal op: CALC in cycles 1..XLEN, FIX in cycle XLEN+1, DONE in cycle XLEN+2 (cycle 34 for XLEN=32).
  - Special case: done in cycle 1.
- stall:
  - High combinationally in the accept cycle and through CALC/FIX.
  - Low in the DONE cycle, so the stalled instruction advances and writes back result that cycle.
- A new start may be accepted in the cycle after DONE (IDLE). A start presented during DONE is ignored.
- rst mid-operation: all outputs reach their reset values at the next edge.

## Test plan
- MUL, op_a = 7, op_b = 6 → done at cycle 34, result 42; stall high in cycles 0–33, low at 34.
- MULH, op_a = 0x80000000, op_b = 0x80000000 → result 0x40000000. MULHSU, op_a = 0xFFFFFFFF, op_b = 0xFFFFFFFF → 0xFFFFFFFF. MULHU, same operands → 0xFFFFFFFE.
- DIV, op_a = -7 (0xFFFFFFF9), op_b = 2 → 0xFFFFFFFD (-3). REM, same operands → 0xFFFFFFFF (-1). DIVU, op_a = 100, op_b = 7 → 14. REMU, same operands → 2.
- Divide by zero, op_a = 0x1234, op_b = 0:
  - DIV → 0xFFFFFFFF, done in cycle 1.
  - REM → 0x1234, done in cycle 1.
- Overflow, op_a = 0x80000000, op_b = 0xFFFFFFFF:
  - DIV → 0x80000000, done in cycle 1.
  - REM → 0, done in cycle 1.
- kill at cycle 10 of a DIV → IDLE at cycle 11, no done pulse. Second start at cycle 5 of a MUL → ignored; only one done, with the first op's result. rst at cycle 20 → all outputs 0 next cycle.
